// File: rtl/apb_master_if.sv
// Host command/response and APB requester signals for apb_master.
// The master modport is the block's view; slave is the host/completer side.
interface apb_master_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_write;
   logic [7:0] cmd_addr;
   logic [7:0] cmd_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       rsp_err;
   logic       rsp_timeout;
   logic       PSEL;
   logic       PENABLE;
   logic       PWRITE;
   logic [7:0] PADDR;
   logic [7:0] PWDATA;
   logic [7:0] PRDATA;
   logic       PREADY;
   logic       PSLVERR;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
             PSEL, PENABLE, PWRITE, PADDR, PWDATA
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
             PSEL, PENABLE, PWRITE, PADDR, PWDATA
   );
endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB requester: host command -> SETUP -> ACCESS -> response pulse.
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES edges without PREADY.
module apb_master #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input logic          PCLK,
   input logic          PRESET,
   apb_master_if.master bus
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES out of range 1..255");
   end

   state_t     state, state_n;
   logic       cmd_ready_q, cmd_ready_n;
   logic       psel_q, psel_n;
   logic       penable_q, penable_n;
   logic       pwrite_q, pwrite_n;
   logic [7:0] paddr_q, paddr_n;
   logic [7:0] pwdata_q, pwdata_n;
   logic       rsp_valid_q, rsp_valid_n;
   logic [7:0] rdata_q, rdata_n;
   logic       err_q, err_n;
`ifdef APB_MASTER_TIMEOUT_EN
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] cnt_q, cnt_n;
   logic       to_q, to_n;
`endif

   always_comb begin
      state_n     = state;
      pwrite_n    = pwrite_q;
      paddr_n     = paddr_q;
      pwdata_n    = pwdata_q;
      rsp_valid_n = 1'b0;
      rdata_n     = rdata_q;
      err_n       = err_q;
`ifdef APB_MASTER_TIMEOUT_EN
      cnt_n       = cnt_q;
      to_n        = to_q;
`endif
      case (state)
         IDLE: begin
            if (bus.cmd_valid) begin
               state_n  = SETUP;
               pwrite_n = bus.cmd_write;
               paddr_n  = bus.cmd_addr;
               pwdata_n = bus.cmd_wdata;
            end
         end
         SETUP: begin
            state_n = ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
            cnt_n   = '0;
`endif
         end
         ACCESS: begin
            // PREADY is checked first so a response on the final allowed edge still completes
            if (bus.PREADY) begin
               state_n     = IDLE;
               rsp_valid_n = 1'b1;
               err_n       = bus.PSLVERR;
               rdata_n     = pwrite_q ? '0 : bus.PRDATA;
`ifdef APB_MASTER_TIMEOUT_EN
               to_n        = 1'b0;
            end else if (cnt_q == CNT_LAST) begin
               state_n     = IDLE;
               rsp_valid_n = 1'b1;
               err_n       = 1'b1;
               rdata_n     = '0;
               to_n        = 1'b1;
               cnt_n       = cnt_q + 8'd1;
            end else begin
               cnt_n       = cnt_q + 8'd1;
`endif
            end
         end
         default: state_n = IDLE;
      endcase
      // Control outputs are registered, so they are derived from the next state
      cmd_ready_n = (state_n == IDLE);
      psel_n      = (state_n != IDLE);
      penable_n   = (state_n == ACCESS);
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state       <= IDLE;
         cmd_ready_q <= 1'b1;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
         cnt_q       <= '0;
         to_q        <= 1'b0;
`endif
      end else begin
         state       <= state_n;
         cmd_ready_q <= cmd_ready_n;
         psel_q      <= psel_n;
         penable_q   <= penable_n;
         pwrite_q    <= pwrite_n;
         paddr_q     <= paddr_n;
         pwdata_q    <= pwdata_n;
         rsp_valid_q <= rsp_valid_n;
         rdata_q     <= rdata_n;
         err_q       <= err_n;
`ifdef APB_MASTER_TIMEOUT_EN
         cnt_q       <= cnt_n;
         to_q        <= to_n;
`endif
      end
   end

   assign bus.cmd_ready   = cmd_ready_q;
   assign bus.PSEL        = psel_q;
   assign bus.PENABLE     = penable_q;
   assign bus.PWRITE      = pwrite_q;
   assign bus.PADDR       = paddr_q;
   assign bus.PWDATA      = pwdata_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_rdata   = rdata_q;
   assign bus.rsp_err     = err_q;
`ifdef APB_MASTER_TIMEOUT_EN
   assign bus.rsp_timeout = to_q;
`else
   assign bus.rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master.sv
// Transaction-level bench for apb_master: directed plus random transfers, per-cycle bus checks.
// Timeout scenarios are exercised when APB_MASTER_TIMEOUT_EN is defined (TIMEOUT_CYCLES=4).
module tb_apb_master;

   localparam int unsigned TO = 4;

   logic PCLK;
   logic PRESET;
   apb_master_if bus ();

   apb_master #(.TIMEOUT_CYCLES(TO)) dut (
      .PCLK   (PCLK),
      .PRESET (PRESET),
      .bus    (bus)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   // Values the outputs must hold between transfers
   logic       exp_write;
   logic [7:0] exp_addr, exp_wdata, exp_rdata;
   logic       exp_err, exp_to;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic noise_cmd(input logic valid);
      bus.cmd_valid = valid;
      bus.cmd_write = 1'($urandom);
      bus.cmd_addr  = 8'($urandom);
      bus.cmd_wdata = 8'($urandom);
   endtask

   task automatic check_held(input string ph);
      check({ph, "_paddr"},  32'(bus.PADDR),       32'(exp_addr));
      check({ph, "_pwdata"}, 32'(bus.PWDATA),      32'(exp_wdata));
      check({ph, "_pwrite"}, 32'(bus.PWRITE),      32'(exp_write));
      check({ph, "_rdata"},  32'(bus.rsp_rdata),   32'(exp_rdata));
      check({ph, "_err"},    32'(bus.rsp_err),     32'(exp_err));
      check({ph, "_to"},     32'(bus.rsp_timeout), 32'(exp_to));
   endtask

   task automatic check_reset_state();
      exp_write = 1'b0; exp_addr = '0; exp_wdata = '0;
      exp_rdata = '0;   exp_err = 1'b0; exp_to = 1'b0;
      check("rst_ready",   32'(bus.cmd_ready), 32'd1);
      check("rst_psel",    32'(bus.PSEL),      32'd0);
      check("rst_penable", 32'(bus.PENABLE),   32'd0);
      check("rst_rvalid",  32'(bus.rsp_valid), 32'd0);
      check_held("rst");
   endtask

   task automatic idle_cycle();
      noise_cmd(1'b0);
      bus.PREADY  = 1'($urandom);
      bus.PSLVERR = 1'($urandom);
      bus.PRDATA  = 8'($urandom);
      tick();
      check("idle_ready",   32'(bus.cmd_ready), 32'd1);
      check("idle_psel",    32'(bus.PSEL),      32'd0);
      check("idle_penable", 32'(bus.PENABLE),   32'd0);
      check("idle_rvalid",  32'(bus.rsp_valid), 32'd0);
      check_held("idle");
   endtask

   // Caller must be in an IDLE cycle; returns in the response cycle with cmd_valid low.
   task automatic xfer(input logic wr, input logic [7:0] addr, input logic [7:0] wd,
                       input logic [7:0] rd, input logic slverr, input int unsigned waits);
      int unsigned k;
      logic done, timed_out;
      check("acc_ready", 32'(bus.cmd_ready), 32'd1);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = wr;
      bus.cmd_addr  = addr;
      bus.cmd_wdata = wd;
      bus.PREADY    = 1'b0;
      tick();
      exp_write = wr; exp_addr = addr; exp_wdata = wd;
      check("setup_psel",    32'(bus.PSEL),      32'd1);
      check("setup_penable", 32'(bus.PENABLE),   32'd0);
      check("setup_ready",   32'(bus.cmd_ready), 32'd0);
      check("setup_rvalid",  32'(bus.rsp_valid), 32'd0);
      check("setup_paddr",   32'(bus.PADDR),     32'(addr));
      check("setup_pwrite",  32'(bus.PWRITE),    32'(wr));
      check("setup_pwdata",  32'(bus.PWDATA),    32'(wd));
      noise_cmd(1'($urandom));
      bus.PREADY  = 1'b1;
      bus.PSLVERR = 1'b1;
      tick();
      k = 0; done = 1'b0; timed_out = 1'b0;
      while (!done) begin
         check("acc_psel",    32'(bus.PSEL),      32'd1);
         check("acc_penable", 32'(bus.PENABLE),   32'd1);
         check("acc_ready",   32'(bus.cmd_ready), 32'd0);
         check("acc_rvalid",  32'(bus.rsp_valid), 32'd0);
         check("acc_paddr",   32'(bus.PADDR),     32'(addr));
         check("acc_pwrite",  32'(bus.PWRITE),    32'(wr));
         check("acc_pwdata",  32'(bus.PWDATA),    32'(wd));
         noise_cmd(1'($urandom));
         if (k == waits) begin
            bus.PREADY  = 1'b1;
            bus.PSLVERR = slverr;
            bus.PRDATA  = rd;
            done = 1'b1;
         end else begin
            bus.PREADY  = 1'b0;
            bus.PSLVERR = 1'b1;
            bus.PRDATA  = 8'($urandom);
`ifdef APB_MASTER_TIMEOUT_EN
            if (k == TO - 1) begin
               done = 1'b1;
               timed_out = 1'b1;
            end
`endif
         end
         tick();
         k++;
      end
      exp_rdata = (timed_out || wr) ? 8'h00 : rd;
      exp_err   = timed_out ? 1'b1 : slverr;
      exp_to    = timed_out;
      check("rsp_valid",   32'(bus.rsp_valid), 32'd1);
      check("rsp_ready",   32'(bus.cmd_ready), 32'd1);
      check("rsp_psel",    32'(bus.PSEL),      32'd0);
      check("rsp_penable", 32'(bus.PENABLE),   32'd0);
      check_held("rsp");
      noise_cmd(1'b0);
      bus.PREADY = 1'b0;
   endtask

   initial begin
      PRESET = 1'b1;
      noise_cmd(1'b1);
      bus.PREADY = 1'b1; bus.PSLVERR = 1'b1; bus.PRDATA = 8'hFF;
      tick();
      tick();
      check_reset_state();
      PRESET = 1'b0;
      idle_cycle();

      // Write with one wait state, read then back-to-back read, error write
      xfer(1'b1, 8'h01, 8'h5A, 8'h33, 1'b0, 1);
      idle_cycle();
      xfer(1'b0, 8'h00, 8'h11, 8'hA5, 1'b0, 0);
      xfer(1'b0, 8'h02, 8'h22, 8'h3C, 1'b0, 0);
      idle_cycle();
      xfer(1'b1, 8'h07, 8'h99, 8'h44, 1'b1, 2);
      idle_cycle();

`ifdef APB_MASTER_TIMEOUT_EN
      xfer(1'b0, 8'h10, 8'h00, 8'h77, 1'b0, 10);
      xfer(1'b0, 8'h11, 8'h00, 8'h78, 1'b1, TO - 1);
      idle_cycle();
`endif

      // Reset in ACCESS with competing PREADY/PSLVERR/cmd_valid
      bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1;
      bus.cmd_addr = 8'hC3; bus.cmd_wdata = 8'h3C;
      tick();
      bus.PREADY = 1'b0;
      tick();
      PRESET = 1'b1;
      noise_cmd(1'b1);
      bus.PREADY = 1'b1; bus.PSLVERR = 1'b1; bus.PRDATA = 8'hEE;
      tick();
      check_reset_state();
      PRESET = 1'b0;
      idle_cycle();
      idle_cycle();

      for (int i = 0; i < 40; i++) begin
         xfer(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
              1'($urandom), $urandom_range(0, 6));
         if ($urandom_range(0, 1) == 0) begin
            for (int j = 0; j < int'($urandom_range(1, 2)); j++) idle_cycle();
         end
      end
      idle_cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, ACCESS-phase cycles with PREADY low before abort; legal range 1..255.
REQ-002 PCLK  input  1  sole clock; all state changes on rising edge.
REQ-003 PRESET  input  1  reset, synchronous, active-high.
REQ-004 cmd_valid  input  1  host requests a transfer.
REQ-005 cmd_ready  output  1  block accepts a command this cycle.
REQ-006 cmd_write  input  1  1 = write, 0 = read.
REQ-007 cmd_addr  input  8  target register address.
REQ-008 cmd_wdata  input  8  write data.
REQ-009 rsp_valid  output  1  one-cycle completion pulse.
REQ-010 rsp_rdata  output  8  read data; 0 for writes and timeouts.
REQ-011 rsp_err  output  1  PSLVERR sampled at completion, or timeout.
REQ-012 rsp_timeout  output  1  transfer aborted by timeout.
REQ-013 PSEL, PENABLE, PWRITE  output  1 each  APB requester controls.
REQ-014 PADDR, PWDATA  output  8 each  APB address and write data.
REQ-015 PRDATA  input  8; PREADY  input  1; PSLVERR  input  1  APB completer responses.

Function
REQ-016 Three states SHALL exist: IDLE, SETUP, ACCESS; all outputs SHALL be registered.
REQ-017 IDLE: cmd_ready=1, PSEL=0, PENABLE=0; cmd_valid high at an edge SHALL capture cmd_write/cmd_addr/cmd_wdata and move to SETUP.
REQ-018 SETUP: PSEL=1, PENABLE=0, cmd_ready=0, PADDR/PWRITE/PWDATA = captured values; unconditional move to ACCESS after exactly one cycle.
REQ-019 ACCESS: PSEL=1, PENABLE=1; PADDR/PWRITE/PWDATA SHALL remain stable through SETUP and all ACCESS cycles.
REQ-020 ACCESS with PREADY=1 at an edge SHALL complete: next cycle PSEL=0, PENABLE=0, state IDLE, rsp_valid=1, rsp_err=PSLVERR, rsp_rdata=PRDATA for reads / 0 for writes, rsp_timeout=0.
REQ-021 PSLVERR and PRDATA SHALL be ignored whenever PREADY=0.
REQ-022 Minimum latency: command accepted at edge N -> rsp_valid high in cycle after edge N+2 (PREADY high on first ACCESS edge).
REQ-023 rsp_valid SHALL be high exactly one cycle; rsp_rdata/rsp_err/rsp_timeout SHALL hold their values until the next completion.
REQ-024 cmd_ready SHALL be high in the rsp_valid cycle; a command then SHALL be accepted, giving back-to-back transfers with one IDLE cycle between.
REQ-025 cmd_valid while cmd_ready=0 SHALL be ignored; no queuing.
REQ-026 In IDLE, PADDR/PWRITE/PWDATA SHALL hold last driven values.

Reset
REQ-027 PRESET high at an edge SHALL force IDLE, cmd_ready=1, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, timeout counter=0.
REQ-028 Reset during SETUP or ACCESS SHALL abandon the transfer with no rsp_valid pulse.
REQ-029 PRESET SHALL take priority over all other inputs in the same cycle.

Configuration
REQ-030 Macro APB_MASTER_TIMEOUT_EN defined: a counter SHALL clear on SETUP->ACCESS and increment each ACCESS edge with PREADY=0; on reaching TIMEOUT_CYCLES, next cycle PSEL=0, PENABLE=0, IDLE, rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-031 With timeout enabled, PREADY=1 on the same edge the counter reaches TIMEOUT_CYCLES SHALL complete normally (PREADY wins).
REQ-032 Macro undefined: no counter logic; ACCESS SHALL wait indefinitely for PREADY; rsp_timeout tied 0.

Verification
REQ-033 Write: cmd addr=0x01 wdata=0x5A, PREADY high on 2nd ACCESS cycle -> PSEL 3 cycles, PENABLE 2 cycles, PWDATA=0x5A stable, rsp_valid pulse, rsp_err=0, rsp_rdata=0.
REQ-034 Read: addr=0x00, PRDATA=0xA5 with PREADY -> rsp_rdata=0xA5, rsp_err=0; then back-to-back read issued in rsp_valid cycle -> SETUP follows immediately.
REQ-035 Error: write addr=0x07, PSLVERR=1 with PREADY -> rsp_err=1, rsp_timeout=0; PSLVERR=1 while PREADY=0 has no effect.
REQ-036 Timeout (APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=4): PREADY held 0 -> abort after 4 ACCESS edges, rsp_err=1, rsp_timeout=1; PREADY=1 on 4th edge -> normal completion.
REQ-037 Reset mid-ACCESS: PRESET pulsed 1 cycle -> all outputs at REQ-027 values next cycle, no rsp_valid; cmd_valid during SETUP/ACCESS ignored.
